// File: rtl/efi_ign_bank.sv
// efi_ign_bank -- bank of N_CH angle-scheduled ignition coil drivers.
//
// Each channel starts dwell (coil charging) when the crank angle equals its
// programmed dwell-start angle and sparks when the angle equals its
// dwell-end angle. A per-channel timer aborts any dwell that lasts too long
// and latches a sticky fault bit.
//
// Config is double-buffered. Writes land in a per-channel shadow and set a
// pending flag. All pending shadows move to the active set together, either
// in any cycle without crank sync or on the strobe at angle 0.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   synced            crank decoder has sync (angle is meaningful only when 1)
//   angle, angle_stb  current crank angle; one-clk pulse on each new value
//   cfg_we, cfg_ch    config write strobe and target channel index
//   cfg_on, cfg_off   dwell-start and spark angles
//   cfg_en            channel enable
//   fault_clr         clears all sticky fault bits
//   ign               coil drive outputs (polarity set by ACTIVE_HIGH)
//   fault             sticky per-channel max-dwell fault
//   busy              at least one channel is dwelling
//
// Handshake: there is no backpressure. angle_stb qualifies angle for
// exactly one cycle. cfg_we qualifies cfg_ch/cfg_on/cfg_off/cfg_en for
// exactly one cycle and is always accepted.
module efi_ign_bank #(
  parameter int N_CH        = 8,
  parameter int ANGLE_W     = 12,
  parameter int ANGLE_MAX   = 2880,
  parameter int DWELL_W     = 20,
  parameter int MAX_DWELL   = 200000,
  parameter bit ACTIVE_HIGH = 1'b1,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               synced,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               angle_stb,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [ANGLE_W-1:0] cfg_on,
  input  logic [ANGLE_W-1:0] cfg_off,
  input  logic               cfg_en,
  input  logic               fault_clr,
  output logic [N_CH-1:0]    ign,
  output logic [N_CH-1:0]    fault,
  output logic               busy
);

  typedef enum logic {S_IDLE = 1'b0, S_DWELL = 1'b1} ch_state_e;

  ch_state_e          state_q  [N_CH];
  ch_state_e          state_d  [N_CH];
  logic [DWELL_W-1:0] timer_q  [N_CH];
  logic [DWELL_W-1:0] timer_d  [N_CH];
  logic [ANGLE_W-1:0] sh_on_q  [N_CH];
  logic [ANGLE_W-1:0] sh_on_d  [N_CH];
  logic [ANGLE_W-1:0] sh_off_q [N_CH];
  logic [ANGLE_W-1:0] sh_off_d [N_CH];
  logic [ANGLE_W-1:0] act_on_q [N_CH];
  logic [ANGLE_W-1:0] act_on_d [N_CH];
  logic [ANGLE_W-1:0] act_off_q[N_CH];
  logic [ANGLE_W-1:0] act_off_d[N_CH];
  logic [N_CH-1:0]    sh_en_q, sh_en_d;
  logic [N_CH-1:0]    act_en_q, act_en_d;
  logic [N_CH-1:0]    pend_q, pend_d;
  logic [N_CH-1:0]    fault_q, fault_d;
  logic [N_CH-1:0]    ign_q, ign_d;
  logic [N_CH-1:0]    dwell_d;
  logic               busy_q, busy_d;
  logic               transfer;
  logic               stb_ok;

  always_comb begin
    transfer  = ~synced | (angle_stb & (angle == '0));
    // The angle-range gate alone is enough to make out-of-range on/off
    // angles never match: an equality hit implies the stored angle is
    // in range as well.
    stb_ok    = angle_stb & synced & (int'(angle) < ANGLE_MAX);
    state_d   = state_q;
    timer_d   = timer_q;
    sh_on_d   = sh_on_q;
    sh_off_d  = sh_off_q;
    sh_en_d   = sh_en_q;
    act_on_d  = act_on_q;
    act_off_d = act_off_q;
    act_en_d  = act_en_q;
    pend_d    = pend_q;
    fault_d   = fault_q & ~{N_CH{fault_clr}};
    dwell_d   = '0;

    for (int i = 0; i < N_CH; i++) begin
      // The transfer moves the old shadow. A write in the same cycle then
      // overwrites the shadow and leaves pending set for the next transfer.
      if (transfer && pend_q[i]) begin
        act_on_d[i]  = sh_on_q[i];
        act_off_d[i] = sh_off_q[i];
        act_en_d[i]  = sh_en_q[i];
        pend_d[i]    = 1'b0;
      end
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        sh_on_d[i]  = cfg_on;
        sh_off_d[i] = cfg_off;
        sh_en_d[i]  = cfg_en;
        pend_d[i]   = 1'b1;
      end

      // Angle matches use the active config held at the start of the cycle.
      // A config transferred on the angle-0 strobe takes effect from the
      // next strobe onward.
      case (state_q[i])
        S_IDLE: begin
          if (stb_ok && act_en_q[i] && (angle == act_on_q[i]) &&
              (act_on_q[i] != act_off_q[i])) begin
            state_d[i] = S_DWELL;
            timer_d[i] = '0;
          end
        end
        S_DWELL: begin
          // Timeout wins over sync loss and over a spark-angle match.
          // The enable bit is not consulted here, so disabling a channel
          // mid-dwell still lets it spark at its off angle.
          if (timer_q[i] == DWELL_W'(MAX_DWELL - 1)) begin
            state_d[i] = S_IDLE;
            fault_d[i] = 1'b1;
          end else if (!synced) begin
            state_d[i] = S_IDLE;
          end else if (stb_ok && (angle == act_off_q[i])) begin
            state_d[i] = S_IDLE;
          end else if (timer_q[i] != DWELL_W'(MAX_DWELL)) begin
            timer_d[i] = timer_q[i] + DWELL_W'(1);
          end
        end
      endcase
      dwell_d[i] = (state_d[i] == S_DWELL);
    end

    ign_d  = ACTIVE_HIGH ? dwell_d : ~dwell_d;
    busy_d = |dwell_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]   <= S_IDLE;
        timer_q[i]   <= '0;
        sh_on_q[i]   <= '0;
        sh_off_q[i]  <= '0;
        act_on_q[i]  <= '0;
        act_off_q[i] <= '0;
      end
      sh_en_q  <= '0;
      act_en_q <= '0;
      pend_q   <= '0;
      fault_q  <= '0;
      ign_q    <= ACTIVE_HIGH ? '0 : '1;
      busy_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]   <= state_d[i];
        timer_q[i]   <= timer_d[i];
        sh_on_q[i]   <= sh_on_d[i];
        sh_off_q[i]  <= sh_off_d[i];
        act_on_q[i]  <= act_on_d[i];
        act_off_q[i] <= act_off_d[i];
      end
      sh_en_q  <= sh_en_d;
      act_en_q <= act_en_d;
      pend_q   <= pend_d;
      fault_q  <= fault_d;
      ign_q    <= ign_d;
      busy_q   <= busy_d;
    end
  end

  assign ign   = ign_q;
  assign fault = fault_q;
  assign busy  = busy_q;

endmodule
